rtc_time_writer: RTL and testbench



---
 rtl/rtc_time_writer_pkg.sv | 40 ++++
 rtl/rtc_time_writer_if.sv | 27 ++
 rtl/rtc_time_writer_shifter.sv | 130 +++++++++++++
 rtl/rtc_time_writer.sv | 126 ++++++++++++
 tb/tb_rtc_time_writer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_time_writer_pkg.sv
// Shared RTC definitions: command bytes, frame count, state encodings, BCD time check.
// RTC_WP_RESTORE_EN adds a final frame that re-enables RTC write-protect.
package rtc_pkg;

  localparam logic [7:0] RTC_CMD_WP     = 8'h8E;
  localparam logic [7:0] RTC_CMD_SEC_W  = 8'h80;
  localparam logic [7:0] RTC_CMD_MIN_W  = 8'h82;
  localparam logic [7:0] RTC_CMD_HOUR_W = 8'h84;
  localparam logic [7:0] RTC_WP_ON      = 8'h80;

`ifdef RTC_WP_RESTORE_EN
  localparam int unsigned RTC_NUM_FRAMES = 5;
`else
  localparam int unsigned RTC_NUM_FRAMES = 4;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, DONE} rtc_state_e;

  typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_e;

  typedef struct packed {
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
  } rtc_time_t;

  // 24h BCD time: every digit a decimal digit, tens digits within their field range.
  function automatic logic rtc_time_valid(input rtc_time_t t);
    logic ok;
    ok = (t.hour1 <= 4'd2) && (t.hour0 <= 4'd9) &&
         (t.min1  <= 4'd5) && (t.min0  <= 4'd9) &&
         (t.sec1  <= 4'd5) && (t.sec0  <= 4'd9);
    if ((t.hour1 == 4'd2) && (t.hour0 > 4'd3)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rtc_time_writer_if.sv
// Time-set request and 3-wire RTC pin bundle for rtc_time_writer.
interface rtc_time_writer_if;
  logic       wr_start;
  logic [3:0] hour1;
  logic [3:0] hour0;
  logic [3:0] min1;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic       busy;
  logic       wr_done;
  logic       wr_err;
  logic       rtc_ce;
  logic       rtc_sclk;
  logic       rtc_io;
  logic       rtc_io_oe;

  modport master (
    output wr_start, hour1, hour0, min1, min0, sec1, sec0,
    input  busy, wr_done, wr_err, rtc_ce, rtc_sclk, rtc_io, rtc_io_oe
  );

  modport slave (
    input  wr_start, hour1, hour0, min1, min0, sec1, sec0,
    output busy, wr_done, wr_err, rtc_ce, rtc_sclk, rtc_io, rtc_io_oe
  );
endinterface

// File: rtl/rtc_time_writer_shifter.sv
// Serialises one 16-bit {data, cmd} frame LSB first on CE/SCLK/IO, 36*CLK_DIV cycles per frame.
module rtc_frame_shifter
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] frame_i,
  output logic        frame_done_o,
  output logic        ce_o,
  output logic        sclk_o,
  output logic        io_o
);

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  rtc_state_e  state_q, state_d;
  logic [8:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  nxt_bit;
  logic        phase_q, phase_d;
  logic [15:0] frame_q, frame_d;
  logic        ce_q, ce_d;
  logic        sclk_q, sclk_d;
  logic        io_q, io_d;
  logic        half_end;
  logic        gap_end;

  assign half_end     = (div_q == HALF_LAST);
  assign gap_end      = (state_q == GAP) && (div_q == GAP_LAST);
  assign nxt_bit      = bit_q + 4'd1;
  assign frame_done_o = gap_end;
  assign ce_o         = ce_q;
  assign sclk_o       = sclk_q;
  assign io_o         = io_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 9'd1;
    bit_d   = bit_q;
    phase_d = phase_q;
    frame_d = frame_q;
    ce_d    = ce_q;
    sclk_d  = sclk_q;
    io_d    = io_q;
    case (state_q)
      IDLE: div_d = '0;
      SETUP: begin
        if (half_end) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          io_d    = frame_q[0];
        end
      end
      SHIFT: begin
        // phase_q=0 is the SCLK-low half where IO may move; phase_q=1 holds IO under SCLK high
        if (half_end) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else if (bit_q == 4'd15) begin
            state_d = HOLD;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
          end else begin
            bit_d   = nxt_bit;
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            io_d    = frame_q[nxt_bit];
          end
        end
      end
      HOLD: begin
        if (half_end) begin
          state_d = GAP;
          div_d   = '0;
          ce_d    = 1'b0;
          io_d    = 1'b0;
        end
      end
      GAP: begin
        if (gap_end) begin
          state_d = IDLE;
          div_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A chained start on the last GAP cycle keeps frames back to back.
    if (start_i && ((state_q == IDLE) || gap_end)) begin
      state_d = SETUP;
      div_d   = '0;
      frame_d = frame_i;
      ce_d    = 1'b1;
      sclk_d  = 1'b0;
      io_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      ce_q    <= 1'b0;
      sclk_q  <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      ce_q    <= ce_d;
      sclk_q  <= sclk_d;
      io_q    <= io_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

endmodule

// File: rtl/rtc_time_writer.sv
// Writes a validated BCD hh:mm:ss to a DS1302-style RTC as a fixed sequence of frames.
// RTC_WP_RESTORE_EN (see rtc_pkg) appends a write-protect restore frame.
module rtc_time_writer
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input logic               clk,
  input logic               rst_n,
  rtc_time_writer_if.slave  bus
);

  seq_state_e state_q, state_d;
  logic [2:0] frame_idx_q, frame_idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] sec_q, min_q, hour_q;
  rtc_time_t  time_in;
  logic       time_ok;
  logic       accept;
  logic       last_frame;
  logic       frame_done;
  logic       sh_start;
  logic [2:0] sel_idx;
  logic [15:0] sh_frame;
  logic       ce, sclk, io;

  function automatic logic [15:0] build_frame(input logic [2:0] idx, input logic [7:0] s,
                                              input logic [7:0] m, input logic [7:0] h);
    case (idx)
      3'd0:    build_frame = {8'h00, RTC_CMD_WP};
      3'd1:    build_frame = {s, RTC_CMD_SEC_W};
      3'd2:    build_frame = {m, RTC_CMD_MIN_W};
      3'd3:    build_frame = {h, RTC_CMD_HOUR_W};
      default: build_frame = {RTC_WP_ON, RTC_CMD_WP};
    endcase
  endfunction

  assign time_in    = '{hour1: bus.hour1, hour0: bus.hour0, min1: bus.min1,
                        min0: bus.min0, sec1: bus.sec1, sec0: bus.sec0};
  assign time_ok    = rtc_time_valid(time_in);
  assign accept     = bus.wr_start && (state_q == SEQ_IDLE) && time_ok;
  assign last_frame = (frame_idx_q == 3'(RTC_NUM_FRAMES - 1));
  assign sh_start   = accept || (frame_done && !last_frame);
  // Frame 0 is constant, so it can launch on the accept edge before the digits are latched.
  assign sel_idx    = accept ? 3'd0 : frame_idx_q + 3'd1;
  assign sh_frame   = build_frame(sel_idx, sec_q, min_q, hour_q);

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (bus.wr_start) begin
          if (time_ok) begin
            state_d     = SEQ_RUN;
            frame_idx_d = '0;
            busy_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEQ_RUN: begin
        if (frame_done) begin
          if (last_frame) begin
            state_d = SEQ_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            frame_idx_d = frame_idx_q + 3'd1;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      frame_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sec_q  <= {1'b0, bus.sec1[2:0], bus.sec0};
      min_q  <= {1'b0, bus.min1[2:0], bus.min0};
      hour_q <= {2'b00, bus.hour1[1:0], bus.hour0};
    end
  end

  rtc_frame_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (sh_start),
    .frame_i      (sh_frame),
    .frame_done_o (frame_done),
    .ce_o         (ce),
    .sclk_o       (sclk),
    .io_o         (io)
  );

  assign bus.busy      = busy_q;
  assign bus.wr_done   = done_q;
  assign bus.wr_err    = err_q;
  assign bus.rtc_ce    = ce;
  assign bus.rtc_sclk  = sclk;
  assign bus.rtc_io    = io;
  assign bus.rtc_io_oe = ce;

endmodule

// File: tb/tb_rtc_time_writer.sv
// Scoreboard bench for rtc_time_writer: directed writes push expected frames/events, a pin monitor decodes and compares.
module tb_rtc_time_writer;

  localparam int K = 4;
`ifdef RTC_WP_RESTORE_EN
  localparam int NF = 5;
`else
  localparam int NF = 4;
`endif
  localparam int XFER = 36 * K * NF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rtc_time_writer_if bus ();

  rtc_time_writer #(.CLK_DIV(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  logic [15:0] exp_frames[$];
  int          exp_done[$];
  int          exp_err[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic check_hex(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%04h required=0x%04h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic ce_p = 0, sclk_p = 0, io_p = 0, busy_p = 0;
  logic gap_valid = 0, busy_valid = 0;
  int   ce_run = 0, sclk_run = 0, nbits = 0, busy_rise = 0;
  logic [15:0] word = '0;
  logic [15:0] exp_w;
  int   exp_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      ce_p = 0; sclk_p = 0; io_p = 0; busy_p = 0;
      gap_valid = 0; busy_valid = 0;
      ce_run = 0; sclk_run = 0; nbits = 0; word = '0;
    end else begin
      if (!bus.busy) gap_valid = 0;
      check("io_oe", bus.rtc_io_oe, bus.rtc_ce);
      if (!bus.rtc_ce) begin
        check("ce_low_sclk", bus.rtc_sclk, 0);
        check("ce_low_io", bus.rtc_io, 0);
      end

      if (bus.rtc_ce && !ce_p) begin
        check("ce_expected", int'(exp_frames.size() > 0), 1);
        if (gap_valid) check("gap_len", ce_run, 2 * K);
        ce_run = 0; nbits = 0; word = '0;
      end else if (!bus.rtc_ce && ce_p) begin
        check("ce_len", ce_run, 34 * K);
        check("sclk_rises", nbits, 16);
        if (exp_frames.size() > 0) begin
          exp_w = exp_frames.pop_front();
          check_hex("frame", word, exp_w);
        end
        gap_valid = 1; ce_run = 0;
      end
      ce_run++;

      if (bus.rtc_sclk != sclk_p) begin
        if (bus.rtc_sclk) begin
          check("sclk_in_ce", bus.rtc_ce, 1);
          if (nbits > 0) check("sclk_low_len", sclk_run, K);
          check("io_at_rise", bus.rtc_io, io_p);
          if (nbits < 16) word[nbits[3:0]] = bus.rtc_io;
          nbits++;
        end else begin
          check("sclk_high_len", sclk_run, K);
        end
        sclk_run = 0;
      end else if (bus.rtc_sclk) begin
        check("io_stable_high", bus.rtc_io, io_p);
      end
      sclk_run++;

      if (bus.busy && !busy_p) begin
        busy_rise = cyc; busy_valid = 1;
      end else if (!bus.busy && busy_p && busy_valid) begin
        check("busy_len", cyc - busy_rise, XFER);
      end

      if (bus.wr_done) begin
        check("done_busy_low", bus.busy, 0);
        check("done_expected", int'(exp_done.size() > 0), 1);
        if (exp_done.size() > 0) begin
          exp_c = exp_done.pop_front();
          check("done_cycle", cyc, exp_c);
        end
        done_seen++;
      end

      if (bus.wr_err) begin
        check("err_expected", int'(exp_err.size() > 0), 1);
        if (exp_err.size() > 0) begin
          exp_c = exp_err.pop_front();
          check("err_cycle", cyc, exp_c);
        end
      end

      ce_p = bus.rtc_ce; sclk_p = bus.rtc_sclk; io_p = bus.rtc_io; busy_p = bus.busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] h1, h0, m1, m0, s1, s0);
    bus.hour1 = h1; bus.hour0 = h0; bus.min1 = m1;
    bus.min0 = m0;  bus.sec1 = s1;  bus.sec0 = s0;
  endtask

  task automatic write_ok(input logic [3:0] h1, h0, m1, m0, s1, s0,
                          input logic [7:0] es, em, eh);
    drive(h1, h0, m1, m0, s1, s0);
    bus.wr_start = 1'b1;
    exp_frames.push_back(16'h008E);
    exp_frames.push_back({es, 8'h80});
    exp_frames.push_back({em, 8'h82});
    exp_frames.push_back({eh, 8'h84});
`ifdef RTC_WP_RESTORE_EN
    exp_frames.push_back(16'h808E);
`endif
    exp_done.push_back(cyc + XFER + 1);
    tick(1);
    bus.wr_start = 1'b0;
  endtask

  task automatic write_bad(input logic [3:0] h1, h0, m1, m0, s1, s0);
    drive(h1, h0, m1, m0, s1, s0);
    bus.wr_start = 1'b1;
    exp_err.push_back(cyc + 1);
    tick(1);
    bus.wr_start = 1'b0;
    tick(3);
    check("err_busy", bus.busy, 0);
    check("err_ce", bus.rtc_ce, 0);
  endtask

  task automatic wait_done();
    int s;
    int n;
    s = done_seen;
    n = 0;
    while (done_seen == s && n < XFER + 50) begin
      tick(1);
      n++;
    end
    check("done_arrived", int'(done_seen != s), 1);
    tick(5);
  endtask

  initial begin
    bus.wr_start = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.wr_done, 0);
    check("rst_err", bus.wr_err, 0);
    check("rst_ce", bus.rtc_ce, 0);
    check("rst_sclk", bus.rtc_sclk, 0);
    check("rst_io", bus.rtc_io, 0);
    check("rst_oe", bus.rtc_io_oe, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // 23:59:58, then a new write launched on its wr_done cycle
    write_ok(2, 3, 5, 9, 5, 8, 8'h58, 8'h59, 8'h23);
    check("busy_after_start", bus.busy, 1);
    tick(XFER);
    check("done_cycle_now", bus.wr_done, 1);
    write_ok(1, 9, 4, 5, 3, 0, 8'h30, 8'h45, 8'h19);
    tick(100);
    drive(0, 0, 0, 0, 0, 0);
    bus.wr_start = 1'b1;
    tick(1);
    bus.wr_start = 1'b0;
    wait_done();

    // abort in F2 bit 7 (frame start +289, bit 7 low phase +349..+352)
    write_ok(0, 1, 0, 2, 0, 3, 8'h03, 8'h02, 8'h01);
    tick(350);
    rst_n = 1'b0;
    #1;
    check("abort_ce", bus.rtc_ce, 0);
    check("abort_sclk", bus.rtc_sclk, 0);
    check("abort_io", bus.rtc_io, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.wr_done, 0);
    exp_frames.delete();
    exp_done.delete();
    tick(3);
    rst_n = 1'b1;
    tick(20);
    write_ok(1, 2, 3, 4, 5, 6, 8'h56, 8'h34, 8'h12);
    wait_done();

    // rejected inputs
    write_bad(2, 4, 0, 0, 0, 0);
    write_bad(2, 4, 0, 10, 0, 0);
    write_bad(1, 2, 6, 0, 0, 0);
    write_bad(1, 2, 0, 0, 6, 0);
    write_bad(3, 0, 0, 0, 0, 0);
    write_bad(1, 2, 0, 0, 0, 15);

    // lower boundary; carries the write-protect restore frame when enabled
    write_ok(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    wait_done();

    tick(10);
    check("frames_left", exp_frames.size(), 0);
    check("done_left", exp_done.size(), 0);
    check("err_left", exp_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
